// File: rtl/watch_edit_ctrl.sv
// watch_edit_ctrl: time-set edit FSM with field select, up/down pulses, hold auto-repeat and inactivity timeout
module watch_edit_ctrl #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [1:0] switch,
  output logic [1:0] sel_pos,
  output logic       inc,
  output logic       dec,
  output logic       edit_active
);
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES)
    ? ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES)
    : ((REPEAT_CYCLES > TIMEOUT_CYCLES) ? REPEAT_CYCLES : TIMEOUT_CYCLES);
  localparam int W = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, EDIT_WAIT, EDIT_HOLD, EDIT_RPT} state_t;

  state_t st, st_n;
  logic [3:0] btn, btn_q, btn_e;
  logic sw_q, armed, sw_e, any_e, dir_up, dir_up_n, inc_n, dec_n, own_btn, opp_btn;
  logic [1:0] sel_n, sel_mv;
  logic [W-1:0] rcnt, rcnt_n, tcnt, tcnt_n, rinc, tinc, rlim;
  logic sw_unused;

  assign sw_unused = switch[0];
  assign btn = {btn_up, btn_down, btn_left, btn_right};
  assign btn_e = btn & ~btn_q;
  assign any_e = |btn_e;
  // armed blocks a switch already high at reset release from looking like an edge
  assign sw_e = switch[1] & ~sw_q & armed;
  assign sel_mv = (btn_e[0] & ~btn_e[1]) ? (sel_pos == 2'd2 ? 2'd0 : sel_pos + 2'd1)
                : (btn_e[1] & ~btn_e[0]) ? (sel_pos == 2'd0 ? 2'd2 : sel_pos - 2'd1)
                : sel_pos;
  assign own_btn = dir_up ? btn_up : btn_down;
  assign opp_btn = dir_up ? btn_down : btn_up;
  assign rinc = (rcnt == W'(MAXC)) ? rcnt : rcnt + W'(1);
  assign tinc = (tcnt == W'(MAXC)) ? tcnt : tcnt + W'(1);
  assign rlim = (st == EDIT_HOLD) ? W'(HOLD_CYCLES) : W'(REPEAT_CYCLES);

  always_comb begin
    st_n = st;
    sel_n = sel_pos;
    inc_n = 1'b0;
    dec_n = 1'b0;
    dir_up_n = dir_up;
    rcnt_n = rcnt;
    tcnt_n = any_e ? '0 : tcnt;
    if (st == IDLE) begin
      sel_n = 2'd0;
      rcnt_n = '0;
      tcnt_n = '0;
      if (sw_e | (any_e & switch[1])) st_n = EDIT_WAIT;
    end else if (!switch[1]) begin
      st_n = IDLE;
      sel_n = 2'd0;
      rcnt_n = '0;
      tcnt_n = '0;
    end else begin
      sel_n = sel_mv;
      if (st == EDIT_WAIT) begin
        if (btn_e[3] & ~btn_down) begin
          inc_n = 1'b1;
          dir_up_n = 1'b1;
          rcnt_n = '0;
          st_n = EDIT_HOLD;
        end else if (btn_e[2] & ~btn_up) begin
          dec_n = 1'b1;
          dir_up_n = 1'b0;
          rcnt_n = '0;
          st_n = EDIT_HOLD;
        end else if (!any_e) begin
          tcnt_n = tinc;
          if (tinc >= W'(TIMEOUT_CYCLES)) begin
            st_n = IDLE;
            sel_n = 2'd0;
            tcnt_n = '0;
          end
        end
      end else if (!own_btn | opp_btn) begin
        st_n = EDIT_WAIT;
        rcnt_n = '0;
      end else begin
        rcnt_n = rinc;
        if (rinc >= rlim) begin
          rcnt_n = '0;
          st_n = EDIT_RPT;
          inc_n = dir_up;
          dec_n = ~dir_up;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      sel_pos <= 2'd0;
      inc <= 1'b0;
      dec <= 1'b0;
      edit_active <= 1'b0;
      rcnt <= '0;
      tcnt <= '0;
      btn_q <= '0;
      sw_q <= 1'b0;
      armed <= 1'b0;
      dir_up <= 1'b0;
    end else begin
      st <= st_n;
      sel_pos <= sel_n;
      inc <= inc_n;
      dec <= dec_n;
      edit_active <= (st_n != IDLE);
      rcnt <= rcnt_n;
      tcnt <= tcnt_n;
      btn_q <= btn;
      sw_q <= switch[1];
      armed <= 1'b1;
      dir_up <= dir_up_n;
    end
  end
endmodule

// File: tb/tb_watch_edit_ctrl.sv
// tb_watch_edit_ctrl: directed and random checks of watch_edit_ctrl against a press-age reference model
module tb_watch_edit_ctrl;
  localparam int H = 4, R = 2, T = 20;
  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LT = 4'b0010, RT = 4'b0001, NB = 4'b0000;
  localparam logic [1:0] SW = 2'b10;

  logic clk = 1'b0, rst = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [1:0] switch = 2'b00;
  logic [1:0] sel_pos;
  logic inc, dec, edit_active;
  int checks = 0, errors = 0;

  int m_mode, m_sel, m_held, m_quiet;
  bit m_dir, m_inc, m_dec, m_armed, p_up, p_dn, p_lt, p_rt, p_sw;

  watch_edit_ctrl #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .switch(switch), .sel_pos(sel_pos), .inc(inc), .dec(dec),
    .edit_active(edit_active)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] mexp();
    return {2'(m_sel), m_inc, m_dec, (m_mode != 0)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_held = 0; m_quiet = 0;
    m_dir = 0; m_inc = 0; m_dec = 0; m_armed = 0;
    p_up = 0; p_dn = 0; p_lt = 0; p_rt = 0; p_sw = 0;
  endtask

  // mode: 0 idle, 1 waiting for a press, 2 a press is being held (m_held = cycles held since press)
  task automatic model_step();
    bit s, ue, de, le, re, any, swe, own, opp;
    s = switch[1];
    ue = btn_up & !p_up; de = btn_down & !p_dn; le = btn_left & !p_lt; re = btn_right & !p_rt;
    any = ue | de | le | re;
    swe = s & !p_sw & m_armed;
    m_inc = 0; m_dec = 0;
    if (m_mode == 0) begin
      m_sel = 0;
      if (swe || (any && s)) begin m_mode = 1; m_quiet = 0; end
    end else if (!s) begin
      m_mode = 0; m_sel = 0;
    end else begin
      if (re && !le) m_sel = (m_sel + 1) % 3;
      else if (le && !re) m_sel = (m_sel + 2) % 3;
      if (any) m_quiet = 0;
      if (m_mode == 1) begin
        if (ue && !btn_down) begin m_inc = 1; m_dir = 1; m_mode = 2; m_held = 0; end
        else if (de && !btn_up) begin m_dec = 1; m_dir = 0; m_mode = 2; m_held = 0; end
        else if (!any) begin
          m_quiet++;
          if (m_quiet >= T) begin m_mode = 0; m_sel = 0; end
        end
      end else begin
        own = m_dir ? btn_up : btn_down;
        opp = m_dir ? btn_down : btn_up;
        if (!own || opp) m_mode = 1;
        else begin
          m_held++;
          if (m_held == H || (m_held > H && (m_held - H) % R == 0)) begin
            m_inc = m_dir; m_dec = !m_dir;
          end
        end
      end
    end
    p_up = btn_up; p_dn = btn_down; p_lt = btn_left; p_rt = btn_right; p_sw = s; m_armed = 1;
  endtask

  task automatic tick(input logic [3:0] b, input logic [1:0] s);
    {btn_up, btn_down, btn_left, btn_right} = b;
    switch = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({sel_pos, inc, dec, edit_active} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {sel_pos, inc, dec, edit_active});
    end
    switch = SW;
    #1 rst = 1'b1;
  endtask

  task automatic test_switch_held_reset();
    for (int i = 0; i < 3; i++) begin
      tick(NB, SW);
      checks++;
      if (edit_active !== 1'b0 || {sel_pos, inc, dec, edit_active} !== mexp()) begin
        errors++; $display("FAIL held_switch_no_entry: got %b want %b", {sel_pos, inc, dec, edit_active}, mexp());
      end
    end
    tick(RT, SW);
    checks++;
    if ({sel_pos, inc, dec, edit_active} !== 5'b00001) begin
      errors++; $display("FAIL wake_by_button: got %b want 00001", {sel_pos, inc, dec, edit_active});
    end
    tick(NB, SW);
    tick(NB, 2'b01);
    checks++;
    if (edit_active !== 1'b0) begin
      errors++; $display("FAIL switch_off_idle: got %b want 0", edit_active);
    end
  endtask

  task automatic test_sel_cycle();
    logic [1:0] want [3] = '{2'd1, 2'd2, 2'd0};
    tick(NB, 2'b00);
    tick(NB, SW);
    checks++;
    if (edit_active !== 1'b1 || sel_pos !== 2'd0) begin
      errors++; $display("FAIL switch_entry: got act=%b sel=%0d want act=1 sel=0", edit_active, sel_pos);
    end
    for (int i = 0; i < 3; i++) begin
      tick(RT, SW);
      checks++;
      if (sel_pos !== want[i] || edit_active !== 1'b1 || {sel_pos, inc, dec, edit_active} !== mexp()) begin
        errors++; $display("FAIL right_step%0d: got sel=%0d act=%b want sel=%0d act=1", i, sel_pos, edit_active, want[i]);
      end
      tick(NB, SW);
    end
  endtask

  task automatic test_autorepeat();
    int hits[$];
    int want [4] = '{1, 5, 7, 9};
    tick(RT, SW);
    tick(NB, SW);
    checks++;
    if (sel_pos !== 2'd1) begin
      errors++; $display("FAIL rpt_sel_setup: got %0d want 1", sel_pos);
    end
    for (int k = 1; k <= 10; k++) begin
      tick(UP, SW);
      if (inc === 1'b1) hits.push_back(k);
      checks++;
      if (dec !== 1'b0 || {sel_pos, inc, dec, edit_active} !== mexp()) begin
        errors++; $display("FAIL rpt_cycle%0d: got %b want %b", k, {sel_pos, inc, dec, edit_active}, mexp());
      end
    end
    checks++;
    if (hits.size() != 4) begin
      errors++; $display("FAIL rpt_pulse_count: got %0d want 4", hits.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hits[i] != want[i]) begin
          errors++; $display("FAIL rpt_pulse_cycle%0d: got %0d want %0d", i, hits[i], want[i]);
        end
      end
    tick(NB, SW);
  endtask

  task automatic test_cancel();
    int pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(DN, SW);
      checks++;
      if ({sel_pos, inc, dec, edit_active} !== mexp()) begin
        errors++; $display("FAIL down_hold%0d: got %b want %b", k, {sel_pos, inc, dec, edit_active}, mexp());
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick(UP | DN, SW);
      pulses += int'(inc) + int'(dec);
    end
    tick(UP, SW);
    pulses += int'(inc) + int'(dec);
    checks++;
    if (pulses != 0 || m_mode != 1) begin
      errors++; $display("FAIL cancel_no_pulse: got %0d pulses want 0", pulses);
    end
    tick(NB, SW);
    tick(UP, SW);
    checks++;
    if (inc !== 1'b1 || dec !== 1'b0) begin
      errors++; $display("FAIL fresh_up_inc: got inc=%b dec=%b want inc=1 dec=0", inc, dec);
    end
    tick(NB, SW);
  endtask

  task automatic test_timeout();
    int drop = -1;
    tick(RT, SW);
    tick(NB, SW);
    for (int i = 1; i <= 25; i++) begin
      tick(NB, SW);
      if (drop < 0 && edit_active === 1'b0) drop = i;
      checks++;
      if ({sel_pos, inc, dec, edit_active} !== mexp()) begin
        errors++; $display("FAIL timeout_cycle%0d: got %b want %b", i, {sel_pos, inc, dec, edit_active}, mexp());
      end
    end
    checks++;
    if (drop != 19 || sel_pos !== 2'd0) begin
      errors++; $display("FAIL timeout_drop: got cycle %0d sel=%0d want cycle 19 sel=0", drop, sel_pos);
    end
    tick(UP, SW);
    checks++;
    if (edit_active !== 1'b1 || inc !== 1'b0) begin
      errors++; $display("FAIL timeout_wake: got act=%b inc=%b want act=1 inc=0", edit_active, inc);
    end
    tick(NB, SW);
  endtask

  task automatic test_reset_mid_repeat();
    for (int i = 0; i < 3 && m_sel != 2; i++) begin
      tick(LT, SW);
      tick(NB, SW);
    end
    for (int k = 0; k < 7; k++) tick(UP, SW);
    checks++;
    if (sel_pos !== 2'd2 || m_mode != 2) begin
      errors++; $display("FAIL mid_rpt_setup: got sel=%0d want 2", sel_pos);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({sel_pos, inc, dec, edit_active} !== 5'b0) begin
      errors++; $display("FAIL async_reset: got %b want 00000", {sel_pos, inc, dec, edit_active});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(UP, SW);
      checks++;
      if (inc !== 1'b0 || {sel_pos, inc, dec, edit_active} !== mexp()) begin
        errors++; $display("FAIL post_reset%0d: got %b want %b", k, {sel_pos, inc, dec, edit_active}, mexp());
      end
    end
    tick(NB, SW);
  endtask

  task automatic test_simultaneous();
    logic [1:0] s0;
    tick(RT, SW);
    tick(NB, SW);
    s0 = sel_pos;
    tick(UP | DN, SW);
    checks++;
    if (inc !== 1'b0 || dec !== 1'b0 || edit_active !== 1'b1) begin
      errors++; $display("FAIL both_updown: got inc=%b dec=%b act=%b want 0 0 1", inc, dec, edit_active);
    end
    tick(NB, SW);
    tick(LT | RT, SW);
    checks++;
    if (sel_pos !== s0 || {sel_pos, inc, dec, edit_active} !== mexp()) begin
      errors++; $display("FAIL both_leftright: got sel=%0d want %0d", sel_pos, s0);
    end
    tick(NB, SW);
  endtask

  task automatic test_random();
    logic [3:0] b = NB;
    logic [1:0] s = SW;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 5) == 0) b[j] = ~b[j];
      if ($urandom_range(0, 79) == 0) s[1] = ~s[1];
      s[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 699) == 0) do_reset();
      tick(b, s);
      checks++;
      if ({sel_pos, inc, dec, edit_active} !== mexp() || (inc & dec)) begin
        errors++; $display("FAIL random%0d: got %b want %b", i, {sel_pos, inc, dec, edit_active}, mexp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch_held_reset();
    test_sel_cycle();
    test_autorepeat();
    test_cancel();
    test_timeout();
    test_reset_mid_repeat();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/watch_edit_ctrl.md
WATCH_EDIT_CTRL -- requirements
Module: watch_edit_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: cycles a held up/down button must stay asserted before auto-repeat starts.
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000: cycles between auto-repeat pulses.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000_000: cycles without button activity before edit mode is abandoned.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced, synchronous, active-high button levels.
REQ-007 switch  input  2  mode switches; switch[1]=1 requests time-set mode; switch[0] is ignored.
REQ-008 sel_pos  output  2  field select to watch datapath: 0=sec, 1=min, 2=hour; value 3 never driven.
REQ-009 inc, dec  output  1 each  single-cycle increment/decrement pulses to watch datapath.
REQ-010 edit_active  output  1  high while in any EDIT state.

Function
REQ-011 FSM states: IDLE, EDIT_WAIT, EDIT_HOLD, EDIT_RPT; all outputs are registered.
REQ-012 Button edges: each button is compared with its value registered on the previous clock; rising edge = current 1, previous 0.
REQ-013 IDLE -> EDIT_WAIT on a switch[1] rising edge, or on any button rising edge while switch[1]=1; the waking edge produces no sel_pos, inc or dec action.
REQ-014 Any EDIT state -> IDLE whenever switch[1]=0; this has priority over every other transition and action in that cycle.
REQ-015 EDIT_WAIT: a btn_right rising edge advances sel_pos 0->1->2->0; a btn_left rising edge steps it 0->2->1->0; if both edges occur in the same cycle, sel_pos is unchanged.
REQ-016 EDIT_WAIT: an up rising edge with btn_down=0 pulses inc and enters EDIT_HOLD.
REQ-017 EDIT_WAIT: a down rising edge with btn_up=0 pulses dec and enters EDIT_HOLD.
REQ-018 EDIT_WAIT: simultaneous up and down edges, or a press of one while the other is held, produce no pulse and no state change.
REQ-019 Pulse latency: inc/dec is high exactly in the cycle after the clock edge that sampled the rising edge; width is exactly 1 cycle.
REQ-020 EDIT_HOLD: a repeat counter increments each cycle while the originating button stays high.
- When the count reaches HOLD_CYCLES, emit one pulse of the same direction, clear the counter, enter EDIT_RPT.
REQ-021 EDIT_RPT: emit one pulse every REPEAT_CYCLES cycles while the button stays high.
REQ-022 EDIT_HOLD/EDIT_RPT: release of the originating button, or assertion of the opposite up/down button, returns to EDIT_WAIT with no pulse that cycle; the repeat counter is cleared.
REQ-023 In EDIT_HOLD/EDIT_RPT, left/right edges still move sel_pos per REQ-015.
REQ-024 inc and dec are never high in the same cycle; both are 0 in IDLE.
REQ-025 Timeout counter:
- cleared on any button rising edge and on entry to EDIT_WAIT from IDLE;
- otherwise increments in EDIT_WAIT only;
- on reaching TIMEOUT_CYCLES the FSM goes to IDLE.
REQ-026 sel_pos resets to 0 on entry to IDLE and holds its value within edit mode.
REQ-027 Counters are sized to hold max(HOLD_CYCLES, REPEAT_CYCLES, TIMEOUT_CYCLES); counting saturates rather than wrapping.

Reset
REQ-028 While rst=0 the block is in IDLE, and the following are all 0: sel_pos, inc, dec, edit_active, all counters, all edge-history registers.
REQ-029 Reset asserted mid-repeat aborts immediately; no pulse is emitted on the cycle after release.
REQ-030 After reset release, a switch[1] already high is not treated as a rising edge; entry requires a button edge per REQ-013.

Verification (HOLD_CYCLES=4, REPEAT_CYCLES=2, TIMEOUT_CYCLES=20)
REQ-031 switch rises 0->2, then btn_right pulsed three times -> edit_active=1; sel_pos goes 1, 2, 0.
REQ-032 In EDIT_WAIT with sel_pos=1, btn_up held 10 cycles -> inc at cycle 1, then cycle 5, then every 2 cycles (7, 9); dec stays 0 throughout.
REQ-033 btn_down held in EDIT_RPT, then btn_up asserted -> no further pulses; state returns to EDIT_WAIT; a fresh btn_up edge after btn_down release yields one inc.
REQ-034 In edit mode, 20 cycles with no buttons -> edit_active=0, sel_pos=0; the next btn_up edge wakes the block without producing inc.
REQ-035 rst driven low while EDIT_RPT is pulsing, with sel_pos=2 -> sel_pos, inc, dec and edit_active are all 0 asynchronously; no pulse after release.
REQ-036 btn_up and btn_down rise in the same cycle, then btn_left and btn_right rise in the same cycle -> no inc, no dec, sel_pos unchanged.
